// File: rtl/flash_boot_loader_if.sv
// flash_boot_loader_if: spi_master and program-RAM signals between the boot loader and its peers
//  master: the boot loader (drives SPI request/ack and RAM writes)
//  slave : spi_master + RAM side (returns bytes, end of transaction, write ready)
interface flash_boot_loader_if #(parameter int MEM_AW = 10);
  logic              spi_en;
  logic [23:0]       spi_addr;
  logic [17:0]       spi_words_to_read;
  logic              spi_read_req;
  logic [7:0]        spi_wr_data;
  logic              spi_rd_ack;
  logic              spi_valid;
  logic [7:0]        spi_rd_data;
  logic              spi_end_trans;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  modport master (
    output spi_en, spi_addr, spi_words_to_read, spi_read_req, spi_wr_data, spi_rd_ack,
    output mem_we, mem_addr, mem_wdata,
    input  spi_valid, spi_rd_data, spi_end_trans, mem_ready
  );
  modport slave (
    input  spi_en, spi_addr, spi_words_to_read, spi_read_req, spi_wr_data, spi_rd_ack,
    input  mem_we, mem_addr, mem_wdata,
    output spi_valid, spi_rd_data, spi_end_trans, mem_ready
  );
endinterface

// File: rtl/flash_boot_loader.sv
// flash_boot_loader: reads one flash image through spi_master and writes it little-endian into program RAM
//  clk, reset          : clock, synchronous active-high reset
//  i_reload            : 1-cycle pulse, reruns the load from DONE
//  bus (master)        : spi_master transaction/readback and RAM write port
//  o_cpu_rst           : holds the CPU in reset until the image is loaded
//  o_busy/o_done/o_error : status; error flags short or overrun loads (sticky until next load)
module flash_boot_loader #(
  parameter logic [23:0] FLASH_BASE  = 24'h100000,
  parameter int          IMAGE_BYTES = 4096,
  parameter int          MEM_AW      = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_reload,
  flash_boot_loader_if.master bus,
  output logic                o_cpu_rst,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error
);
  typedef enum logic [1:0] {START, COLLECT, ACK, DONE} state_t;
  localparam logic [17:0] IMG = 18'(IMAGE_BYTES);
  state_t r_state, w_state_nxt;
  logic r_spi_en, r_spi_rd_ack, r_mem_we, r_cpu_rst, r_busy, r_done, r_error;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [23:0] r_stage;
  logic [17:0] r_byte_cnt, w_cnt_nxt;
  logic w_xfer, w_take, w_drop, w_exit;
  assign bus.spi_en            = r_spi_en;
  assign bus.spi_addr          = FLASH_BASE;
  assign bus.spi_words_to_read = 18'(IMAGE_BYTES * 8);
  assign bus.spi_read_req      = 1'b1;
  assign bus.spi_wr_data       = 8'h00;
  assign bus.spi_rd_ack        = r_spi_rd_ack;
  assign bus.mem_we            = r_mem_we;
  assign bus.mem_addr          = r_mem_addr;
  assign bus.mem_wdata         = r_mem_wdata;
  assign o_cpu_rst             = r_cpu_rst;
  assign o_busy                = r_busy;
  assign o_done                = r_done;
  assign o_error               = r_error;
  // A 4th byte arriving while the previous word still waits for RAM has nowhere to go: drop it.
  always_comb begin
    w_xfer      = r_mem_we && bus.mem_ready;
    w_take      = r_state == COLLECT && bus.spi_valid;
    w_drop      = w_take && r_byte_cnt[1:0] == 2'd3 && r_mem_we && !bus.mem_ready;
    w_cnt_nxt   = r_byte_cnt + 18'(w_take && !w_drop);
    w_exit      = r_state == COLLECT && bus.spi_end_trans && !r_mem_we;
    w_state_nxt = r_state == START ? COLLECT :
                  w_exit ? ACK :
                  r_state == ACK ? DONE :
                  r_state == DONE && i_reload ? START : r_state;
  end
  always_ff @(posedge clk)
    r_state <= reset ? START : w_state_nxt;
  // Bytes 0..2 shift into r_stage from the top so byte 0 lands in bits 7:0 once the word completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_spi_en     <= 1'b0;
      r_spi_rd_ack <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rst    <= 1'b1;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_stage      <= '0;
      r_byte_cnt   <= '0;
    end else begin
      r_spi_en     <= r_state == START;
      r_spi_rd_ack <= w_exit;
      r_done       <= w_state_nxt == DONE;
      r_cpu_rst    <= w_state_nxt != DONE;
      r_busy       <= w_state_nxt != DONE;
      r_byte_cnt   <= r_state == START ? '0 : w_cnt_nxt;
      if (w_xfer) begin
        r_mem_we   <= 1'b0;
        r_mem_addr <= r_mem_addr + MEM_AW'(1);
      end
      if (r_state == START) begin
        r_mem_addr <= '0;
        r_error    <= 1'b0;
        r_stage    <= '0;
      end
      if (w_drop || (w_exit && w_cnt_nxt != IMG))
        r_error <= 1'b1;
      if (w_take && !w_drop) begin
        if (r_byte_cnt[1:0] == 2'd3) begin
          r_mem_wdata <= {bus.spi_rd_data, r_stage};
          r_mem_we    <= 1'b1;
        end else
          r_stage <= {bus.spi_rd_data, r_stage[23:8]};
      end
    end
  end
endmodule

// File: tb/tb_flash_boot_loader.sv
// tb_flash_boot_loader: directed scenarios for flash_boot_loader with an 8-byte image
module tb_flash_boot_loader;
  logic clk = 1'b0, reset = 1'b1, reload = 1'b0;
  logic cpu_rst, busy, done, error;
  int checks = 0, errors = 0;
  int en_cnt = 0, ack_cnt = 0, wr_cnt = 0;
  logic [3:0] log_addr [64];
  logic [31:0] log_data [64];
  logic [7:0] img [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  flash_boot_loader_if #(.MEM_AW(4)) bus ();
  flash_boot_loader #(.FLASH_BASE(24'h100000), .IMAGE_BYTES(8), .MEM_AW(4)) dut (
    .clk(clk), .reset(reset), .i_reload(reload), .bus(bus),
    .o_cpu_rst(cpu_rst), .o_busy(busy), .o_done(done), .o_error(error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.spi_en) en_cnt++;
    if (bus.spi_rd_ack) ack_cnt++;
    if (bus.mem_we && bus.mem_ready) begin
      log_addr[wr_cnt % 64] = bus.mem_addr;
      log_data[wr_cnt % 64] = bus.mem_wdata;
      wr_cnt++;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.spi_en) begin ok = 1'b1; break; end
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    bus.spi_valid = 1'b1;
    bus.spi_rd_data = b;
    @(negedge clk);
    bus.spi_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic finish_trans(output bit ok);
    bus.spi_end_trans = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.spi_rd_ack) begin ok = 1'b1; break; end
    end
    bus.spi_end_trans = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({bus.spi_en, bus.spi_rd_ack, bus.mem_we} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {bus.spi_en, bus.spi_rd_ack, bus.mem_we}); end
    checks++; if ({cpu_rst, busy, done, error} !== 4'b1100) begin errors++; $display("FAIL reset_status: got %b want 1100", {cpu_rst, busy, done, error}); end
    checks++; if (bus.mem_addr !== 4'd0 || bus.mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.spi_addr !== 24'h100000 || bus.spi_words_to_read !== 18'd64) begin errors++; $display("FAIL spi_consts: got %h/%0d want 100000/64", bus.spi_addr, bus.spi_words_to_read); end
    checks++; if (bus.spi_read_req !== 1'b1 || bus.spi_wr_data !== 8'h00) begin errors++; $display("FAIL spi_rw: got %b/%h want 1/00", bus.spi_read_req, bus.spi_wr_data); end
  endtask
  task automatic test_basic();
    int w0, e0, a0;
    bit ok;
    w0 = wr_cnt; e0 = en_cnt; a0 = ack_cnt;
    bus.mem_ready = 1'b1;
    reset = 1'b0;
    wait_en(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_en: got no spi_en want spi_en"); end
    for (int i = 0; i < 8; i++) send_byte(img[i]);
    finish_trans(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_ack: got no spi_rd_ack want spi_rd_ack"); end
    checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL basic_writes: got %0d want 2", wr_cnt - w0); end
    checks++; if (log_addr[w0 % 64] !== 4'd0 || log_data[w0 % 64] !== 32'h44332211) begin errors++; $display("FAIL basic_word0: got %h@%0d want 44332211@0", log_data[w0 % 64], log_addr[w0 % 64]); end
    checks++; if (log_addr[(w0 + 1) % 64] !== 4'd1 || log_data[(w0 + 1) % 64] !== 32'h88776655) begin errors++; $display("FAIL basic_word1: got %h@%0d want 88776655@1", log_data[(w0 + 1) % 64], log_addr[(w0 + 1) % 64]); end
    checks++; if (en_cnt - e0 !== 1 || ack_cnt - a0 !== 1) begin errors++; $display("FAIL basic_pulses: got en %0d ack %0d want 1 1", en_cnt - e0, ack_cnt - a0); end
    checks++; if ({cpu_rst, busy, done, error} !== 4'b0010) begin errors++; $display("FAIL basic_status: got %b want 0010", {cpu_rst, busy, done, error}); end
  endtask
  task automatic test_stall();
    int w0;
    bit ok, held;
    do_reset();
    w0 = wr_cnt;
    bus.mem_ready = 1'b0;
    wait_en(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_en: got no spi_en want spi_en"); end
    for (int i = 0; i < 4; i++) send_byte(img[i]);
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h44332211) held = 1'b0;
      bus.spi_valid = (i == 2 || i == 4 || i == 6);
      bus.spi_rd_data = i == 2 ? 8'h55 : i == 4 ? 8'h66 : 8'h77;
      @(negedge clk);
    end
    bus.spi_valid = 1'b0;
    checks++; if (!held) begin errors++; $display("FAIL stall_hold: got mem_we/wdata changed want held 44332211"); end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    send_byte(img[7]);
    finish_trans(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_ack: got no spi_rd_ack want spi_rd_ack"); end
    checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL stall_writes: got %0d want 2", wr_cnt - w0); end
    checks++; if (log_data[w0 % 64] !== 32'h44332211 || log_data[(w0 + 1) % 64] !== 32'h88776655 || log_addr[(w0 + 1) % 64] !== 4'd1) begin errors++; $display("FAIL stall_data: got %h %h@%0d want 44332211 88776655@1", log_data[w0 % 64], log_data[(w0 + 1) % 64], log_addr[(w0 + 1) % 64]); end
    checks++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL stall_status: got %b want 10", {done, error}); end
  endtask
  task automatic test_overrun();
    int w0, a0;
    bit ok;
    do_reset();
    w0 = wr_cnt;
    bus.mem_ready = 1'b0;
    wait_en(ok);
    for (int i = 0; i < 8; i++) send_byte(img[i]);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovr_err: got %b want 1", error); end
    a0 = ack_cnt;
    bus.spi_end_trans = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1 || ack_cnt != a0 || done !== 1'b0) begin errors++; $display("FAIL ovr_wait: got we %b acks %0d done %b want 1 0 0", bus.mem_we, ack_cnt - a0, done); end
    bus.mem_ready = 1'b1;
    finish_trans(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovr_ack: got no spi_rd_ack want spi_rd_ack"); end
    checks++; if (wr_cnt - w0 !== 1 || log_data[w0 % 64] !== 32'h44332211 || log_addr[w0 % 64] !== 4'd0) begin errors++; $display("FAIL ovr_writes: got %0d %h@%0d want 1 44332211@0", wr_cnt - w0, log_data[w0 % 64], log_addr[w0 % 64]); end
    checks++; if ({done, error, cpu_rst} !== 3'b110) begin errors++; $display("FAIL ovr_status: got %b want 110", {done, error, cpu_rst}); end
  endtask
  task automatic test_short();
    int w0;
    bit ok;
    do_reset();
    w0 = wr_cnt;
    bus.mem_ready = 1'b1;
    wait_en(ok);
    for (int i = 0; i < 6; i++) send_byte(img[i]);
    finish_trans(ok);
    checks++; if (!ok) begin errors++; $display("FAIL short_ack: got no spi_rd_ack want spi_rd_ack"); end
    checks++; if (wr_cnt - w0 !== 1 || log_data[w0 % 64] !== 32'h44332211 || log_addr[w0 % 64] !== 4'd0) begin errors++; $display("FAIL short_writes: got %0d %h@%0d want 1 44332211@0", wr_cnt - w0, log_data[w0 % 64], log_addr[w0 % 64]); end
    checks++; if ({done, error} !== 2'b11) begin errors++; $display("FAIL short_status: got %b want 11", {done, error}); end
  endtask
  task automatic test_reset_mid();
    int w0, e0;
    bit ok;
    do_reset();
    bus.mem_ready = 1'b1;
    wait_en(ok);
    for (int i = 0; i < 3; i++) send_byte(img[i]);
    bus.spi_valid = 1'b1;
    bus.spi_rd_data = img[3];
    reset = 1'b1;
    @(negedge clk);
    bus.spi_valid = 1'b0;
    checks++; if ({bus.spi_en, bus.spi_rd_ack, bus.mem_we, cpu_rst, busy, done, error} !== 7'b0001100) begin errors++; $display("FAIL mid_ctl: got %b want 0001100", {bus.spi_en, bus.spi_rd_ack, bus.mem_we, cpu_rst, busy, done, error}); end
    checks++; if (bus.mem_addr !== 4'd0 || bus.mem_wdata !== 32'd0) begin errors++; $display("FAIL mid_mem: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
    reset = 1'b0;
    w0 = wr_cnt; e0 = en_cnt;
    wait_en(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_en: got no spi_en want spi_en"); end
    for (int i = 0; i < 8; i++) send_byte(img[i]);
    finish_trans(ok);
    checks++; if (wr_cnt - w0 !== 2 || log_data[w0 % 64] !== 32'h44332211 || log_data[(w0 + 1) % 64] !== 32'h88776655) begin errors++; $display("FAIL mid_reload: got %0d %h %h want 2 44332211 88776655", wr_cnt - w0, log_data[w0 % 64], log_data[(w0 + 1) % 64]); end
    checks++; if (en_cnt - e0 !== 1 || {done, error} !== 2'b10) begin errors++; $display("FAIL mid_status: got en %0d %b want 1 10", en_cnt - e0, {done, error}); end
  endtask
  task automatic test_reload();
    int w0, e0;
    bit ok;
    w0 = wr_cnt; e0 = en_cnt;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checks++; if ({cpu_rst, done, busy} !== 3'b101) begin errors++; $display("FAIL reload_start: got %b want 101", {cpu_rst, done, busy}); end
    wait_en(ok);
    checks++; if (!ok) begin errors++; $display("FAIL reload_en: got no spi_en want spi_en"); end
    for (int i = 0; i < 2; i++) send_byte(img[i]);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    for (int i = 2; i < 8; i++) send_byte(img[i]);
    finish_trans(ok);
    checks++; if (!ok) begin errors++; $display("FAIL reload_ack: got no spi_rd_ack want spi_rd_ack"); end
    checks++; if (wr_cnt - w0 !== 2 || log_addr[w0 % 64] !== 4'd0 || log_data[w0 % 64] !== 32'h44332211) begin errors++; $display("FAIL reload_word0: got %0d %h@%0d want 2 44332211@0", wr_cnt - w0, log_data[w0 % 64], log_addr[w0 % 64]); end
    checks++; if (log_addr[(w0 + 1) % 64] !== 4'd1 || log_data[(w0 + 1) % 64] !== 32'h88776655) begin errors++; $display("FAIL reload_word1: got %h@%0d want 88776655@1", log_data[(w0 + 1) % 64], log_addr[(w0 + 1) % 64]); end
    checks++; if (en_cnt - e0 !== 1 || {done, error, cpu_rst} !== 3'b100) begin errors++; $display("FAIL reload_status: got en %0d %b want 1 100", en_cnt - e0, {done, error, cpu_rst}); end
  endtask
  initial begin
    bus.spi_valid = 1'b0;
    bus.spi_rd_data = 8'h00;
    bus.spi_end_trans = 1'b0;
    bus.mem_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_short();
    test_reset_mid();
    test_reload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
